// File: rtl/beta_boot_loader.sv
// Boot loader for the Beta core: streams a counted, XOR-checksummed image into
// instruction memory and releases the core from reset once the image verifies.
module beta_boot_loader #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_WAIT_COUNT,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [1:0]          idx_q, idx_d;
  logic [23:0]         sh_q, sh_d;
  logic [7:0]          acc_q, acc_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         wdata_d;
  logic [CNT_W-1:0]    wl_d, wl_inc;
  logic                accept;
  logic                idle_expired;

  assign accept       = rx_valid && rx_ready;
  assign idle_expired = (idle_q == IDLE_W'(TIMEOUT - 1));
  assign wl_inc       = words_loaded + CNT_W'(1);

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    idle_d  = idle_q;
    we_d    = 1'b0;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    wl_d    = words_loaded;

    case (state_q)
      S_WAIT_COUNT: begin
        if (accept) begin
          acc_d  = 8'd0;
          idle_d = '0;
          idx_d  = 2'd0;
          if (rx_data == 8'd0) begin
            state_d = S_CHECK;
          end else if (32'(rx_data) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            n_d     = CNT_W'(rx_data);
            wl_d    = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          idle_d = '0;
          sh_d   = {sh_q[15:0], rx_data};
          acc_d  = acc_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_loaded[ADDR_W-1:0];
            wdata_d = {sh_q, rx_data};
            wl_d    = wl_inc;
            if (wl_inc == n_q) state_d = S_CHECK;
          end
        end else if (idle_expired) begin
          state_d = S_ERR;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      S_CHECK: begin
        if (accept) begin
          idle_d  = '0;
          state_d = (rx_data == acc_q) ? S_DONE : S_ERR;
        end else if (idle_expired) begin
          state_d = S_ERR;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Registered state, datapath and state-decoded outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT_COUNT;
      n_q          <= '0;
      idx_q        <= 2'd0;
      sh_q         <= 24'd0;
      acc_q        <= 8'd0;
      idle_q       <= '0;
      rx_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      acc_q        <= acc_d;
      idle_q       <= idle_d;
      rx_ready     <= (state_d == S_WAIT_COUNT) || (state_d == S_LOAD) || (state_d == S_CHECK);
      imem_we      <= we_d;
      imem_addr    <= addr_d;
      imem_wdata   <= wdata_d;
      cpu_rst      <= (state_d != S_DONE);
      busy         <= (state_d == S_LOAD) || (state_d == S_CHECK);
      error        <= (state_d == S_ERR);
      words_loaded <= wl_d;
    end
  end

endmodule

// File: tb/tb_beta_boot_loader.sv
// Self-checking bench for beta_boot_loader: table-driven and random image loads
// compared against a stream-parsing reference model, plus directed corner cases.
module tb_beta_boot_loader;

  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned TMO   = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          error;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  beta_boot_loader #(.ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy),
    .error(error), .words_loaded(words_loaded)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int unsigned count;
    bit          bad;
    int          gap;
    bit          exp_err;
    int unsigned exp_words;
  } vec_t;

  wr_t cap_q[$];
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture every memory write the DUT issues
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      wr_t w;
      w.addr = imem_addr;
      w.data = imem_wdata;
      cap_q.push_back(w);
      chk("wl_at_write", 64'(words_loaded), 64'(imem_addr) + 64'd1);
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    cap_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    rx_valid = 1'b0;
    tick(gap);
    rx_valid = 1'b1;
    rx_data  = b;
    k = 0;
    while (!rx_ready && k < 20) begin tick(1); k++; end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: rx_ready stayed 0 for byte %0h", b);
    end else begin
      tick(1);
    end
    rx_valid = 1'b0;
  endtask

  // Reference: parse the stream directly into expected writes and outcome
  task automatic model(input byte_q_t s, output bit done, output bit err, output int unsigned words);
    int unsigned n;
    logic [7:0]  x;
    exp_q.delete();
    done  = 0;
    err   = 0;
    words = 0;
    n     = s[0];
    if (n > DEPTH) begin
      err = 1;
    end else begin
      x = 8'd0;
      for (int w = 0; w < int'(n); w++) begin
        wr_t e;
        e.addr = AW'(w);
        e.data = {s[1+4*w], s[2+4*w], s[3+4*w], s[4+4*w]};
        for (int j = 1; j <= 4; j++) x = x ^ s[4*w+j];
        exp_q.push_back(e);
      end
      words = n;
      if (s.size() > 1 + 4 * n) begin
        if (s[1+4*n] == x) done = 1;
        else err = 1;
      end
    end
  endtask

  function automatic byte_q_t make_stream(input int unsigned count, input bit bad);
    byte_q_t    s;
    logic [7:0] x, b;
    s.push_back(8'(count));
    if (count <= DEPTH) begin
      x = 8'd0;
      for (int i = 0; i < int'(4 * count); i++) begin
        b = 8'($urandom);
        x = x ^ b;
        s.push_back(b);
      end
      if (bad) x = x ^ 8'($urandom_range(1, 255));
      s.push_back(x);
    end
    return s;
  endfunction

  task automatic compare_writes(input string tag);
    chk({tag, "_nwrites"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      chk({tag, "_addr"}, 64'(cap_q[i].addr), 64'(exp_q[i].addr));
      chk({tag, "_data"}, 64'(cap_q[i].data), 64'(exp_q[i].data));
    end
  endtask

  task automatic run_stream(input byte_q_t s, input int gap, input string tag,
                            output bit done, output bit err, output int unsigned words);
    do_reset();
    model(s, done, err, words);
    for (int i = 0; i < s.size(); i++) send_byte(s[i], (i == 0) ? 0 : gap);
    tick(3);
    compare_writes(tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
  endtask

  vec_t vecs[9];

  initial begin
    byte_q_t     s;
    bit          m_done, m_err;
    int unsigned m_words;
    logic [7:0]  x;

    vecs[0] = '{count: 1,    bad: 0, gap: 0, exp_err: 0, exp_words: 1};
    vecs[1] = '{count: 2,    bad: 0, gap: 2, exp_err: 0, exp_words: 2};
    vecs[2] = '{count: 2,    bad: 1, gap: 0, exp_err: 1, exp_words: 2};
    vecs[3] = '{count: 33,   bad: 0, gap: 0, exp_err: 1, exp_words: 0};
    vecs[4] = '{count: 0,    bad: 0, gap: 0, exp_err: 0, exp_words: 0};
    vecs[5] = '{count: 32,   bad: 0, gap: 0, exp_err: 0, exp_words: 32};
    vecs[6] = '{count: 255,  bad: 0, gap: 0, exp_err: 1, exp_words: 0};
    vecs[7] = '{count: 7,    bad: 0, gap: 1, exp_err: 0, exp_words: 7};
    vecs[8] = '{count: 32,   bad: 1, gap: 3, exp_err: 1, exp_words: 32};

    // Reset values
    do_reset();
    chk("rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);

    // Fixed image; its checksum (XOR of the 8 data bytes) is 0x44
    do_reset();
    s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 0);
    rx_valid = 1'b1;
    rx_data  = 8'hDD;
    tick(1);
    chk("last_byte_we", 64'(imem_we), 64'd1);
    chk("last_byte_addr", 64'(imem_addr), 64'd1);
    chk("last_byte_wdata", 64'(imem_wdata), 64'hAABBCCDD);
    chk("last_byte_words", 64'(words_loaded), 64'd2);
    chk("last_byte_busy", 64'(busy), 64'd1);
    chk("last_byte_ready", 64'(rx_ready), 64'd1);
    chk("last_byte_cpu_rst", 64'(cpu_rst), 64'd1);
    rx_data = 8'h44;
    tick(1);
    rx_valid = 1'b0;
    chk("release_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("release_we", 64'(imem_we), 64'd0);
    chk("release_busy", 64'(busy), 64'd0);
    chk("release_ready", 64'(rx_ready), 64'd0);
    chk("release_error", 64'(error), 64'd0);
    chk("fixed_nwrites", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2) begin
      chk("fixed_addr0", 64'(cap_q[0].addr), 64'd0);
      chk("fixed_data0", 64'(cap_q[0].data), 64'h11223344);
      chk("fixed_addr1", 64'(cap_q[1].addr), 64'd1);
      chk("fixed_data1", 64'(cap_q[1].data), 64'hAABBCCDD);
    end
    // Bytes offered after DONE are ignored
    repeat (5) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      tick(1);
      rx_valid = 1'b0;
      tick(1);
    end
    chk("post_done_nwrites", 64'(cap_q.size()), 64'd2);
    chk("post_done_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("post_done_ready", 64'(rx_ready), 64'd0);
    chk("post_done_words", 64'(words_loaded), 64'd2);

    // Same image with a wrong checksum
    do_reset();
    s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 0);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    tick(1);
    rx_valid = 1'b0;
    chk("badsum_error", 64'(error), 64'd1);
    chk("badsum_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("badsum_ready", 64'(rx_ready), 64'd0);

    // Oversized count fails one cycle after the count byte
    do_reset();
    rx_valid = 1'b1;
    rx_data  = 8'h21;
    tick(1);
    rx_valid = 1'b0;
    chk("bigcount_error", 64'(error), 64'd1);
    chk("bigcount_ready", 64'(rx_ready), 64'd0);
    tick(3);
    chk("bigcount_nwrites", 64'(cap_q.size()), 64'd0);

    // Gaps just under the timeout are tolerated; a full timeout stall is not
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h5C, 5);
    send_byte(8'h3E, TMO - 1);
    send_byte(8'h91, TMO - 1);
    send_byte(8'h07, TMO - 1);
    tick(TMO - 1);
    chk("tmo_before_error", 64'(error), 64'd0);
    chk("tmo_before_busy", 64'(busy), 64'd1);
    tick(1);
    chk("tmo_error", 64'(error), 64'd1);
    chk("tmo_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_nwrites", 64'(cap_q.size()), 64'd1);
    if (cap_q.size() == 1) begin
      chk("tmo_addr", 64'(cap_q[0].addr), 64'd0);
      chk("tmo_data", 64'(cap_q[0].data), 64'h5C3E9107);
    end

    // Reset in the middle of a word, then a clean single-word image
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    rst = 1'b1;
    tick(1);
    chk("midrst_ready", 64'(rx_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("midrst_words", 64'(words_loaded), 64'd0);
    rst = 1'b0;
    cap_q.delete();
    s = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    x = 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
    s.push_back(x);
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 0);
    tick(2);
    chk("midrst_nwrites", 64'(cap_q.size()), 64'd1);
    if (cap_q.size() == 1) begin
      chk("midrst_addr", 64'(cap_q[0].addr), 64'd0);
      chk("midrst_data", 64'(cap_q[0].data), 64'hDEADBEEF);
    end
    chk("midrst_release", 64'(cpu_rst), 64'd0);

    // Table-driven images with random payloads
    foreach (vecs[i]) begin
      s = make_stream(vecs[i].count, vecs[i].bad);
      run_stream(s, vecs[i].gap, $sformatf("vec%0d", i), m_done, m_err, m_words);
      chk($sformatf("vec%0d_error", i), 64'(error), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_cpu_rst", i), 64'(cpu_rst), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_words", i), 64'(words_loaded), 64'(vecs[i].exp_words));
    end

    // Random images judged by the reference model alone
    for (int r = 0; r < 10; r++) begin
      s = make_stream($urandom_range(0, 40), ($urandom_range(0, 3) == 0));
      run_stream(s, $urandom_range(0, 3), $sformatf("rnd%0d", r), m_done, m_err, m_words);
      chk($sformatf("rnd%0d_error", r), 64'(error), 64'(m_err));
      chk($sformatf("rnd%0d_cpu_rst", r), 64'(cpu_rst), 64'(!m_done));
      chk($sformatf("rnd%0d_words", r), 64'(words_loaded), 64'(m_words));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
